// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared state encoding, BCD digit limits and time helpers.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package stopwatch_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] TENTHS_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_MAX    = 4'd9;
  localparam logic [DIGIT_W-1:0] TENS_MAX   = 4'd5;
  localparam logic [DIGIT_W-1:0] MIN_MAX    = 4'd9;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    LAP_HOLD = 2'd2,
    STOP     = 2'd3
  } sw_state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] min;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] sec;
    logic [DIGIT_W-1:0] tenths;
  } sw_time_t;

  function automatic logic time_is_max(input sw_time_t t);
    return (t.min == MIN_MAX) && (t.tens == TENS_MAX) &&
           (t.sec == SEC_MAX) && (t.tenths == TENTHS_MAX);
  endfunction

  // Ripple-carry BCD increment; 9.59.9 rolls over to 0.00.0.
  function automatic sw_time_t time_inc(input sw_time_t t);
    sw_time_t n;
    n = t;
    if (t.tenths == TENTHS_MAX) begin
      n.tenths = '0;
      if (t.sec == SEC_MAX) begin
        n.sec = '0;
        if (t.tens == TENS_MAX) begin
          n.tens = '0;
          if (t.min == MIN_MAX) n.min = '0;
          else                  n.min = t.min + 4'd1;
        end else begin
          n.tens = t.tens + 4'd1;
        end
      end else begin
        n.sec = t.sec + 4'd1;
      end
    end else begin
      n.tenths = t.tenths + 4'd1;
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// Module      : button_debouncer
// Description : 2-FF synchronizer, debounce counter and rising-edge press pulse.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_q;
  logic             r_armed;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  logic w_eff_level;
  logic w_diff;
  logic w_accept;

  // Until a stable low has been seen after reset the button is treated as
  // held, so a button pressed through reset never produces a press.
  assign w_eff_level = r_level | ~r_armed;
  assign w_diff      = r_sync2 ^ w_eff_level;
  assign w_accept    = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_armed   <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;

      if (!w_diff || w_accept) r_cnt <= '0;
      else                     r_cnt <= r_cnt + 1'b1;

      if (w_accept) begin
        if (r_armed) r_level <= r_sync2;
        else         r_armed <= 1'b1;
      end

      r_level_q <= r_level;
      r_press   <= r_level & ~r_level_q;
    end
  end

  assign o_press = r_press;

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Stopwatch sequencer: 0.1 s timebase, BCD M.SS.T counter, lap FSM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV        = 10_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               btn_start,
  input  logic               btn_lap,
  input  logic               btn_clear,
  output logic [DIGIT_W-1:0] hex3,
  output logic [DIGIT_W-1:0] hex2,
  output logic [DIGIT_W-1:0] hex1,
  output logic [DIGIT_W-1:0] hex0,
  output logic               running,
  output logic               lap_active,
  output logic               overflow
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  sw_state_t        r_state;
  logic [PRE_W-1:0] r_presc;
  sw_time_t         r_time;
  sw_time_t         r_snap;
  sw_time_t         r_hex;
  logic             r_running;
  logic             r_lap_active;
  logic             r_overflow;

  logic     w_p_start;
  logic     w_p_lap;
  logic     w_p_clear;
  logic     w_start;
  logic     w_lap;
  logic     w_clear;
  logic     w_counting;
  logic     w_tick;
  logic     w_wrap;
  logic     w_enter_lap;
  logic     w_hold_nxt;
  logic     w_run_nxt;
  logic     w_do_clear;
  sw_time_t w_time_live;
  sw_time_t w_live_nxt;
  sw_time_t w_snap_nxt;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clock), .rst_n(reset_n), .i_btn(btn_start), .o_press(w_p_start)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk(clock), .rst_n(reset_n), .i_btn(btn_lap), .o_press(w_p_lap)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(clock), .rst_n(reset_n), .i_btn(btn_clear), .o_press(w_p_clear)
  );

  // Same-cycle presses resolve clear > start > lap.
  assign w_clear = w_p_clear;
  assign w_start = w_p_start & ~w_p_clear;
  assign w_lap   = w_p_lap & ~w_p_start & ~w_p_clear;

  assign w_counting  = (r_state == RUN) || (r_state == LAP_HOLD);
  assign w_tick      = w_counting && (r_presc == PRE_LAST);
  assign w_wrap      = w_tick && time_is_max(r_time);
  assign w_time_live = w_tick ? time_inc(r_time) : r_time;

  // Next-state summaries so the display registers land with the state change.
  assign w_enter_lap = (r_state == RUN) && !w_start && w_lap;
  assign w_hold_nxt  = w_enter_lap || ((r_state == LAP_HOLD) && !w_start && !w_lap);
  assign w_run_nxt   = ((r_state == IDLE)     &&  w_start) ||
                       ((r_state == RUN)      && !w_start) ||
                       ((r_state == LAP_HOLD) && !w_start) ||
                       ((r_state == STOP)     &&  w_start);
  assign w_do_clear  = (r_state == STOP) && !w_start && w_clear;
  assign w_live_nxt  = w_do_clear ? sw_time_t'('0) : w_time_live;
  assign w_snap_nxt  = w_enter_lap ? w_time_live : r_snap;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_presc      <= '0;
      r_time       <= '0;
      r_snap       <= '0;
      r_hex        <= '0;
      r_running    <= 1'b0;
      r_lap_active <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) r_state <= RUN;
        end
        RUN: begin
          if (w_start)    r_state <= STOP;
          else if (w_lap) r_state <= LAP_HOLD;
        end
        LAP_HOLD: begin
          if (w_start)    r_state <= STOP;
          else if (w_lap) r_state <= RUN;
        end
        STOP: begin
          if (w_start)      r_state <= RUN;
          else if (w_clear) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_do_clear || w_tick) r_presc <= '0;
      else if (w_counting)      r_presc <= r_presc + 1'b1;

      r_time       <= w_live_nxt;
      r_snap       <= w_snap_nxt;
      r_overflow   <= w_do_clear ? 1'b0 : (r_overflow | w_wrap);
      r_running    <= w_run_nxt;
      r_lap_active <= w_hold_nxt;
      r_hex        <= w_hold_nxt ? w_snap_nxt : w_live_nxt;
    end
  end

  assign hex3       = r_hex.min;
  assign hex2       = r_hex.tens;
  assign hex1       = r_hex.sec;
  assign hex0       = r_hex.tenths;
  assign running    = r_running;
  assign lap_active = r_lap_active;
  assign overflow   = r_overflow;

endmodule

`default_nettype wire
